// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC iteration controller: state encoding, default
// counter width and the phase codes seen by the CNU/VNU arrays.
package ldpc_pkg;

    localparam int ITER_W_DEF = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CNU   = 3'd2,
        S_VNU   = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_NONE = 2'd0;
    localparam phase_t PH_LOAD = 2'd1;
    localparam phase_t PH_CNU  = 2'd2;
    localparam phase_t PH_VNU  = 2'd3;

    function automatic phase_t phase_of(input state_e s);
        phase_t p;
        case (s)
            S_LOAD:  p = PH_LOAD;
            S_CNU:   p = PH_CNU;
            S_VNU:   p = PH_VNU;
            default: p = PH_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ldpc_iter_ctrl_if.sv
// Control/status bundle between the decoder datapath (master) and the
// iteration controller (slave).
interface ldpc_iter_ctrl_if import ldpc_pkg::*; #(parameter int ITER_W = ITER_W_DEF);

    logic              start;
    logic              abort;
    logic [ITER_W-1:0] max_iter;
    logic              cnu_done;
    logic              vnu_done;
    logic              syndrome_ok;
    logic              load_en;
    logic              cnu_en;
    logic              vnu_en;
    logic              hard_dec_en;
    logic              busy;
    logic              done;
    logic              converged;
    logic [ITER_W-1:0] iter_cnt;

    modport master (
        output start, abort, max_iter, cnu_done, vnu_done, syndrome_ok,
        input  load_en, cnu_en, vnu_en, hard_dec_en, busy, done, converged, iter_cnt
    );

    modport slave (
        input  start, abort, max_iter, cnu_done, vnu_done, syndrome_ok,
        output load_en, cnu_en, vnu_en, hard_dec_en, busy, done, converged, iter_cnt
    );

endinterface

// File: rtl/ldpc_iter_counter.sv
// Completed-iteration counter with latched limit (0 treated as 1), saturating
// at the limit, plus terminal and last-iteration compares.
module ldpc_iter_counter #(
    parameter int ITER_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [ITER_W-1:0] lim_in,
    output logic [ITER_W-1:0] cnt,
    output logic              at_limit,
    output logic              at_last
);

    localparam logic [ITER_W-1:0] ONE  = ITER_W'(1'b1);
    localparam logic [ITER_W-1:0] ZERO = {ITER_W{1'b0}};

    logic [ITER_W-1:0] cnt_r;
    logic [ITER_W-1:0] lim_r;

    // Count and limit registers; clear also captures the new limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO;
            lim_r <= ONE;
        end else if (clr) begin
            cnt_r <= ZERO;
            lim_r <= (lim_in == ZERO) ? ONE : lim_in;
        end else if (inc && (cnt_r != lim_r)) begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign cnt      = cnt_r;
    assign at_limit = (cnt_r == lim_r);
    assign at_last  = (cnt_r == (lim_r - ONE));

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC decode iteration FSM: LOAD, then CNU/VNU/CHECK rounds until the limit.
// Define LDPC_EARLY_TERM_EN to finish early when the syndrome is satisfied.
module ldpc_iter_ctrl import ldpc_pkg::*; #(
    parameter int ITER_W = ITER_W_DEF
) (
    input logic              clk,
    input logic              rst,
    ldpc_iter_ctrl_if.slave  bus
);

    state_e            state_r;
    state_e            state_s;
    phase_t            ph_s;
    logic              clr_s;
    logic              inc_s;
    logic [ITER_W-1:0] cnt_s;
    logic              at_limit_s;
    logic              at_last_s;
    logic              load_en_r;
    logic              cnu_en_r;
    logic              vnu_en_r;
    logic              hard_dec_en_r;
    logic              busy_r;
    logic              done_r;
    logic              converged_r;

    ldpc_iter_counter #(.ITER_W(ITER_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .inc      (inc_s),
        .lim_in   (bus.max_iter),
        .cnt      (cnt_s),
        .at_limit (at_limit_s),
        .at_last  (at_last_s)
    );

    // Next-state and counter-control decode; abort overrides everything.
    always_comb begin
        state_s = state_r;
        clr_s   = 1'b0;
        inc_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_s = S_LOAD;
                    clr_s   = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD:  state_s = S_CNU;
            S_CNU: begin
                if (bus.cnu_done) begin
                    state_s = S_VNU;
                end else begin
                    state_s = S_CNU;
                end
            end
            S_VNU: begin
                if (bus.vnu_done) begin
                    state_s = S_CHECK;
                    inc_s   = 1'b1;
                end else begin
                    state_s = S_VNU;
                end
            end
            S_CHECK: begin
`ifdef LDPC_EARLY_TERM_EN
                if (bus.syndrome_ok || at_limit_s) begin
`else
                if (at_limit_s) begin
`endif
                    state_s = S_DONE;
                end else begin
                    state_s = S_CNU;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
        if (bus.abort && (state_r != S_IDLE)) begin
            state_s = S_IDLE;
            clr_s   = 1'b0;
            inc_s   = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    assign ph_s = phase_of(state_s);

    // State and registered outputs, decoded from the next state so they line
    // up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            load_en_r     <= 1'b0;
            cnu_en_r      <= 1'b0;
            vnu_en_r      <= 1'b0;
            hard_dec_en_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            converged_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            load_en_r     <= (ph_s == PH_LOAD);
            cnu_en_r      <= (ph_s == PH_CNU);
            vnu_en_r      <= (ph_s == PH_VNU);
            // Count is stable across entry to and residence in VNU.
            hard_dec_en_r <= (ph_s == PH_VNU) && at_last_s;
            busy_r        <= (state_s != S_IDLE);
            done_r        <= (state_s == S_DONE);
            if (clr_s) begin
                converged_r <= 1'b0;
            end else if ((state_r == S_CHECK) && (state_s == S_DONE)) begin
                converged_r <= bus.syndrome_ok;
            end
        end
    end

    assign bus.load_en     = load_en_r;
    assign bus.cnu_en      = cnu_en_r;
    assign bus.vnu_en      = vnu_en_r;
    assign bus.hard_dec_en = hard_dec_en_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.converged   = converged_r;
    assign bus.iter_cnt    = cnt_s;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl: table of full decode runs plus abort,
// ignored-start and mid-run reset sequences. Honors LDPC_EARLY_TERM_EN.
module tb_ldpc_iter_ctrl;
    import ldpc_pkg::*;

    localparam int W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ldpc_iter_ctrl_if #(.ITER_W(W)) bus();
    ldpc_iter_ctrl #(.ITER_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // datapath responder state: each done arrives on the 2nd cycle of its enable
    int c_cnt, v_cnt, vnu_count, vnu_idx, syn_at;
    bit pending, prev_vnu;

    typedef struct {
        logic [W-1:0] mi;
        int           syn;
        int           pairs;
        int           hd_cyc;
        int           hd_idx;
        int           iter;
        logic         conv;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_resp();
        c_cnt = 0; v_cnt = 0; vnu_count = 0; vnu_idx = 0;
        pending = 1'b0; prev_vnu = 1'b0;
        bus.cnu_done = 1'b0; bus.vnu_done = 1'b0; bus.syndrome_ok = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.cnu_en === 1'b1) begin
            c_cnt++;
            bus.cnu_done = (c_cnt >= 2);
        end else begin
            c_cnt = 0;
            bus.cnu_done = 1'b0;
        end
        if ((bus.vnu_en === 1'b1) && !prev_vnu) vnu_idx++;
        prev_vnu = (bus.vnu_en === 1'b1);
        if (pending) begin
            bus.syndrome_ok = (vnu_count == syn_at);
            pending = 1'b0;
        end else begin
            bus.syndrome_ok = 1'b0;
        end
        if (bus.vnu_en === 1'b1) begin
            v_cnt++;
            bus.vnu_done = (v_cnt >= 2);
            if (v_cnt == 2) begin
                vnu_count++;
                pending = 1'b1;
            end
        end else begin
            v_cnt = 0;
            bus.vnu_done = 1'b0;
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.load_en, bus.cnu_en, bus.vnu_en, bus.hard_dec_en,
                bus.busy, bus.done, bus.converged};
    endfunction

    task automatic run_decode(input logic [W-1:0] mi, input int syn, input string tag);
        int loads = 0, dones = 0, hd_cyc = 0, hd_idx = 0, hd_bad = 0;
        logic [W-1:0] it = '0;
        logic cv = 1'b0, post_busy = 1'b1, post_done = 1'b1;
        bit got = 1'b0;
        reset_resp();
        syn_at = syn;
        bus.max_iter = mi;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (bus.load_en === 1'b1) loads++;
            if (bus.hard_dec_en === 1'b1) begin
                hd_cyc++;
                hd_idx = vnu_idx;
                if (bus.vnu_en !== 1'b1) hd_bad++;
            end
            if (bus.done === 1'b1) begin
                dones++;
                it = bus.iter_cnt;
                cv = bus.converged;
                got = 1'b1;
                step();
                post_busy = bus.busy;
                post_done = bus.done;
                chk({tag, " iter_hold"}, bus.iter_cnt, it);
                break;
            end
            step();
        end
        chk({tag, " timeout"}, got, 1);
        chk({tag, " load_cycles"}, loads, 1);
        chk({tag, " done_pulses"}, dones, 1);
        chk({tag, " hd_bad"}, hd_bad, 0);
        chk({tag, " post_busy"}, post_busy, 0);
        chk({tag, " post_done"}, post_done, 0);
        last_pairs = vnu_count; last_hd_cyc = hd_cyc; last_hd_idx = hd_idx;
        last_iter = it; last_conv = cv;
    endtask

    int last_pairs, last_hd_cyc, last_hd_idx;
    logic [W-1:0] last_iter;
    logic last_conv;

    initial begin
        bit hd_seen;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.max_iter = '0;
        reset_resp();

        vecs[0] = '{6'd3, 0, 3, 2, 3, 3, 1'b0};
`ifdef LDPC_EARLY_TERM_EN
        vecs[1] = '{6'd8, 2, 2, 0, 0, 2, 1'b1};
        vecs[5] = '{6'd5, 3, 3, 0, 0, 3, 1'b1};
`else
        vecs[1] = '{6'd8, 2, 8, 2, 8, 8, 1'b0};
        vecs[5] = '{6'd5, 3, 5, 2, 5, 5, 1'b0};
`endif
        vecs[2] = '{6'd0, 0, 1, 2, 1, 1, 1'b0};
        vecs[3] = '{6'd1, 1, 1, 2, 1, 1, 1'b1};
        vecs[4] = '{6'd2, 2, 2, 2, 2, 2, 1'b1};

        step(); step();
        chk("reset_outs", outs(), 7'd0);
        chk("reset_iter", bus.iter_cnt, 0);
        rst = 1'b0;
        step();
        chk("idle_outs", outs(), 7'd0);

        for (int i = 0; i < 6; i++) begin
            run_decode(vecs[i].mi, vecs[i].syn, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d pairs", i), last_pairs, vecs[i].pairs);
            chk($sformatf("vec%0d hd_cycles", i), last_hd_cyc, vecs[i].hd_cyc);
            chk($sformatf("vec%0d hd_vnu_idx", i), last_hd_idx, vecs[i].hd_idx);
            chk($sformatf("vec%0d iter_cnt", i), last_iter, vecs[i].iter);
            chk($sformatf("vec%0d converged", i), last_conv, vecs[i].conv);
        end

        // abort together with vnu_done and start in the 2nd VNU; start held while busy
        reset_resp();
        syn_at = 0;
        hd_seen = 1'b0;
        bus.max_iter = 6'd4;
        bus.start = 1'b1;
        step();
        bus.max_iter = 6'd1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (bus.hard_dec_en === 1'b1) hd_seen = 1'b1;
            if (vnu_idx == 2) break;
        end
        chk("abort reach_vnu2", bus.vnu_en, 1);
        chk("busy_start no_hd", hd_seen, 0);
        chk("abort pre_iter", bus.iter_cnt, 1);
        bus.vnu_done = 1'b1;
        bus.abort = 1'b1;
        step();
        chk("abort outs", outs(), 7'd0);
        chk("abort iter", bus.iter_cnt, 1);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        step();
        chk("abort no_done", bus.done, 0);
        chk("abort idle", bus.busy, 0);

        // synchronous reset in the 2nd CNU phase, then a clean run
        reset_resp();
        bus.max_iter = 6'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if ((vnu_count == 1) && (bus.cnu_en === 1'b1)) break;
        end
        chk("rst reach_cnu2", bus.cnu_en, 1);
        chk("rst pre_iter", bus.iter_cnt, 1);
        rst = 1'b1;
        step();
        chk("rst outs", outs(), 7'd0);
        chk("rst iter", bus.iter_cnt, 0);
        rst = 1'b0;
        step();
        run_decode(6'd2, 0, "post_rst");
        chk("post_rst pairs", last_pairs, 2);
        chk("post_rst hd_idx", last_hd_idx, 2);
        chk("post_rst iter_cnt", last_iter, 2);
        chk("post_rst converged", last_conv, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
